// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the ARM datapath (slave).
interface multicycle_ctrl_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;
  logic        illegal;
  logic [3:0]  state;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal, state
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore controller for the multicycle ARM datapath: sequencing, NZCV flags,
// condition evaluation and predication of every architectural write.
module multicycle_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ok_q, cond_ok_d;

  logic [3:0] cond, rd, unused_rn;
  logic [1:0] op;
  logic [5:0] funct;
  logic       dp_legal, is_addsub;
  logic [1:0] dp_alu;

  // Instr carries IR[31:12]
  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign funct     = bus.Instr[13:8];
  assign unused_rn = bus.Instr[7:4];
  assign rd        = bus.Instr[3:0];

  always_comb begin
    dp_legal = 1'b1;
    dp_alu   = 2'b00;
    case (funct[4:1])
      4'b0100: dp_alu = 2'b00;
      4'b0010: dp_alu = 2'b01;
      4'b0000: dp_alu = 2'b10;
      4'b1100: dp_alu = 2'b11;
      default: dp_legal = 1'b0;
    endcase
  end

  assign is_addsub = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010);

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, res;
    {n, z, cy, v} = f;
    res = 1'b0;
    case (c)
      4'h0: res = z;
      4'h1: res = !z;
      4'h2: res = cy;
      4'h3: res = !cy;
      4'h4: res = n;
      4'h5: res = !n;
      4'h6: res = v;
      4'h7: res = !v;
      4'h8: res = cy && !z;
      4'h9: res = !cy || z;
      4'hA: res = (n == v);
      4'hB: res = (n != v);
      4'hC: res = !z && (n == v);
      4'hD: res = z || (n != v);
      4'hE: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Next state, condition latch and flag update
  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    cond_ok_d = cond_ok_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        cond_ok_d = cond_eval(cond, flags_q);
        case (op)
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          2'b00:   state_d = !dp_legal ? UNKNOWN : (funct[5] ? EXECUTEI : EXECUTER);
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:  state_d = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD: state_d = MEMWB;
      EXECUTER, EXECUTEI: begin
        state_d = ALUWB;
        if (cond_ok_q && funct[0]) begin
          flags_d[3:2] = bus.ALUFlags[3:2];
          if (is_addsub) flags_d[1:0] = bus.ALUFlags[1:0];
        end
      end
      UNKNOWN: state_d = ILLEGAL_HALT ? UNKNOWN : FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      flags_q   <= 4'h0;
      cond_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ok_q <= cond_ok_d;
    end
  end

  // Moore outputs; enables are held low for as long as reset is asserted
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.RegSrc     = 2'b00;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ImmSrc     = 2'b00;
    bus.ALUControl = 2'b00;
    bus.illegal    = 1'b0;
    bus.state      = state_q;
    case (state_q)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.PCWrite   = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR:  bus.ALUSrcB = 2'b01;
      MEMREAD: bus.AdrSrc  = 1'b1;
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = cond_ok_q;
      end
      MEMWB, ALUWB: begin
        bus.ResultSrc = (state_q == MEMWB) ? 2'b01 : 2'b00;
        bus.RegWrite  = cond_ok_q;
        bus.PCWrite   = cond_ok_q && (rd == 4'hF);
      end
      EXECUTER: bus.ALUControl = dp_alu;
      EXECUTEI: begin
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = dp_alu;
      end
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = cond_ok_q;
      end
      UNKNOWN: bus.illegal = 1'b1;
      default: ;
    endcase
    if (state_q != FETCH) begin
      bus.RegSrc = {(op == 2'b01) && !funct[0], op == 2'b10};
      bus.ImmSrc = op;
    end
    if (reset) begin
      bus.PCWrite  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      bus.IRWrite  = 1'b0;
    end
  end

endmodule
